// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control FSM driving the data_path control inputs.
// Walks each instruction through FETCH -> DECODE -> (EXEC -> WAIT -> WB | MEM) -> FETCH.
// All outputs are registered. Each register is loaded on the edge that enters
// the state in which the value must be visible.
module cpu_controller (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_ir_in,
  input  logic        i_dp_en_out,
  input  logic        i_alu_zero,
  output logic        o_en_pc,
  output logic [1:0]  o_pc_ctrl,
  output logic [7:0]  o_offset,
  output logic        o_en_in,
  output logic [3:0]  o_reg_en,
  output logic        o_alu_in_sel,
  output logic [2:0]  o_alu_func,
  output logic [1:0]  o_rd,
  output logic [1:0]  o_rs,
  output logic        o_mem_to_reg,
  output logic        o_ram_we,
  output logic        o_halted,
  output logic        o_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT = 8'd15;

  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_MVI  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADI  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_MEM, S_HALTED
  } state_t;

  state_t           r_state;
  logic [3:0]       r_ir_op;
  logic             r_z_flag;
  logic [CNT_W-1:0] r_cnt;

  logic             r_en_pc;
  logic [1:0]       r_pc_ctrl;
  logic [7:0]       r_offset;
  logic             r_en_in;
  logic [3:0]       r_reg_en;
  logic             r_alu_in_sel;
  logic [2:0]       r_alu_func;
  logic [1:0]       r_rd;
  logic [1:0]       r_rs;
  logic             r_mem_to_reg;
  logic             r_ram_we;
  logic             r_halted;
  logic             r_err;

  logic [2:0]       w_func_in;
  logic             w_sel_in;
  logic [3:0]       w_rd_onehot;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_rd_onehot = 4'(1) << r_rd;
  assign w_cnt_next  = r_cnt + CNT_W'(1);

  // ALU function / operand-b select for the incoming instruction word
  always_comb begin
    w_func_in = 3'b000;
    w_sel_in  = 1'b0;
    case (i_ir_in[15:12])
      OP_MVI: w_sel_in = 1'b1;
      OP_ADD: w_func_in = 3'b001;
      OP_ADI: begin
        w_func_in = 3'b001;
        w_sel_in  = 1'b1;
      end
      OP_SUB: w_func_in = 3'b010;
      OP_AND: w_func_in = 3'b011;
      OP_OR:  w_func_in = 3'b100;
      default: ;
    endcase
  end

  // Control FSM with registered outputs; strobes default low so each lasts one cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_ir_op      <= 4'h0;
      r_z_flag     <= 1'b0;
      r_cnt        <= '0;
      r_en_pc      <= 1'b0;
      r_pc_ctrl    <= PC_HOLD;
      r_offset     <= 8'h00;
      r_en_in      <= 1'b0;
      r_reg_en     <= 4'b0000;
      r_alu_in_sel <= 1'b0;
      r_alu_func   <= 3'b000;
      r_rd         <= 2'b00;
      r_rs         <= 2'b00;
      r_mem_to_reg <= 1'b0;
      r_ram_we     <= 1'b0;
      r_halted     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_en_pc      <= 1'b0;
      r_pc_ctrl    <= PC_HOLD;
      r_en_in      <= 1'b0;
      r_reg_en     <= 4'b0000;
      r_mem_to_reg <= 1'b0;
      r_ram_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          // Fields latch here and stay stable until the next FETCH
          r_ir_op      <= i_ir_in[15:12];
          r_rd         <= i_ir_in[11:10];
          r_rs         <= i_ir_in[9:8];
          r_offset     <= i_ir_in[7:0];
          r_alu_func   <= w_func_in;
          r_alu_in_sel <= w_sel_in;
          r_state      <= S_DECODE;
          // PC-only instructions complete in DECODE, so their strobe is set now
          case (i_ir_in[15:12])
            OP_MOV, OP_MVI, OP_ADD, OP_ADI, OP_SUB, OP_AND, OP_OR,
            OP_LD, OP_ST, OP_HALT: ;
            OP_JMP: begin
              r_en_pc   <= 1'b1;
              r_pc_ctrl <= PC_LOAD;
            end
            OP_JZ: begin
              r_en_pc   <= 1'b1;
              r_pc_ctrl <= r_z_flag ? PC_LOAD : PC_INC;
            end
            default: begin
              r_en_pc   <= 1'b1;
              r_pc_ctrl <= PC_INC;
            end
          endcase
        end
        S_DECODE: begin
          case (r_ir_op)
            OP_MOV, OP_MVI, OP_ADD, OP_ADI, OP_SUB, OP_AND, OP_OR: begin
              r_en_in <= 1'b1;
              r_state <= S_EXEC;
            end
            OP_LD: begin
              r_mem_to_reg <= 1'b1;
              r_reg_en     <= w_rd_onehot;
              r_en_in      <= 1'b1;
              r_en_pc      <= 1'b1;
              r_pc_ctrl    <= PC_INC;
              r_state      <= S_MEM;
            end
            OP_ST: begin
              r_ram_we  <= 1'b1;
              r_en_pc   <= 1'b1;
              r_pc_ctrl <= PC_INC;
              r_state   <= S_MEM;
            end
            OP_HALT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALTED;
            end
            default: r_state <= S_FETCH;
          endcase
        end
        S_EXEC: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A late pulse on the final cycle still wins over the timeout
          if (i_dp_en_out) begin
            r_z_flag  <= i_alu_zero;
            r_reg_en  <= w_rd_onehot;
            r_en_in   <= 1'b1;
            r_en_pc   <= 1'b1;
            r_pc_ctrl <= PC_INC;
            r_state   <= S_WB;
          end else if (w_cnt_next == TIMEOUT) begin
            r_cnt    <= w_cnt_next;
            r_err    <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_WB, S_MEM: r_state <= S_FETCH;
        S_HALTED: r_state <= S_HALTED;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_en_pc      = r_en_pc;
  assign o_pc_ctrl    = r_pc_ctrl;
  assign o_offset     = r_offset;
  assign o_en_in      = r_en_in;
  assign o_reg_en     = r_reg_en;
  assign o_alu_in_sel = r_alu_in_sel;
  assign o_alu_func   = r_alu_func;
  assign o_rd         = r_rd;
  assign o_rs         = r_rs;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_ram_we     = r_ram_we;
  assign o_halted     = r_halted;
  assign o_err        = r_err;

endmodule
